// File: rtl/ustc_drain.sv
// ustc_drain: captures accumulator row bursts into a row FIFO and writes them out through a registered valid/ready head.
// Optional USTC_DRAIN_RELU_EN: when defined, negative elements are clamped to zero as rows are pushed.

module ustc_drain #(
    parameter int M           = 16,
    parameter int N           = 16,
    parameter int DW_DATA     = 8,
    parameter int DEPTH       = 16,
    parameter int AW          = 16,
    parameter int ADDR_STRIDE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AW-1:0]             base_addr,
    input  logic                      in_valid,
    input  logic [N*DW_DATA-1:0]      in_data,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [AW-1:0]             mem_addr,
    output logic [N*DW_DATA-1:0]      mem_data,
    output logic                      mem_last,
    output logic                      done,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int RW = N * DW_DATA;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(M + 1);

    typedef struct packed {
        logic          last;
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } entry_t;

    entry_t        fifo_q [DEPTH];

    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    entry_t        head_q, head_d;
    logic          mem_valid_q, mem_valid_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;

    logic          in_accept;
    logic          full, empty;
    logic          head_load, pop, push, drop;
    logic [AW-1:0] row_addr;
    logic [RW-1:0] row_data;
    entry_t        push_entry;

`ifdef USTC_DRAIN_RELU_EN
    always_comb begin
        row_data = in_data;
        for (int i = 0; i < N; i++) begin
            if (in_data[i*DW_DATA + DW_DATA - 1]) begin
                row_data[i*DW_DATA +: DW_DATA] = '0;
            end
        end
    end
`else
    assign row_data = in_data;
`endif

    // The first beat of a burst uses base_addr directly; later beats use the latched copy.
    always_comb begin
        in_accept = in_valid && (in_cnt_q < CW'(M));
        base_d    = (in_accept && (in_cnt_q == '0)) ? base_addr : base_q;
        row_addr  = (in_cnt_q == '0) ? base_addr
                                     : base_q + AW'(32'(in_cnt_q) * ADDR_STRIDE);
        push_entry.last = (in_cnt_q == CW'(M - 1));
        push_entry.addr = row_addr;
        push_entry.data = row_data;

        if (!in_valid) begin
            in_cnt_d = '0;
        end else if (in_accept) begin
            in_cnt_d = in_cnt_q + CW'(1);
        end else begin
            in_cnt_d = in_cnt_q;
        end
    end

    always_comb begin
        full      = (level_q == LW'(DEPTH));
        empty     = (level_q == '0);
        head_load = !mem_valid_q || mem_ready;
        pop       = head_load && !empty;
        push      = in_accept && (!full || pop);
        drop      = in_accept && full && !pop;

        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q || drop;
    end

    // Head register: refills when empty or on a handshake, otherwise holds stable.
    always_comb begin
        head_d      = head_q;
        mem_valid_d = mem_valid_q;
        if (head_load) begin
            mem_valid_d = !empty;
            if (!empty) begin
                head_d = fifo_q[rd_ptr_q];
            end
        end
        done_d = mem_valid_q && mem_ready && head_q.last;
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_q    <= '0;
            base_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            head_q      <= '0;
            mem_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            base_q      <= base_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            head_q      <= head_d;
            mem_valid_q <= mem_valid_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = head_q.addr;
    assign mem_data  = head_q.data;
    assign mem_last  = head_q.last;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign level     = level_q;

endmodule

// File: tb/tb_ustc_drain.sv
// Directed bench for ustc_drain: one DEPTH=16 and one DEPTH=4 instance share the same stimulus.
// Expected rows are regenerated from their address; handshakes are checked in order as they happen.

module tb_ustc_drain;

    localparam int M  = 16;
    localparam int N  = 16;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int W  = N * DW;

`ifdef USTC_DRAIN_RELU_EN
    localparam logic [7:0] NEG_EXP = 8'h00;
`else
    localparam logic [7:0] NEG_EXP = 8'h80;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          mem_ready;

    logic          a_mem_valid, a_mem_last, a_done, a_overflow;
    logic [AW-1:0] a_mem_addr;
    logic [W-1:0]  a_mem_data;
    logic [4:0]    a_level;

    logic          b_mem_valid, b_mem_last, b_done, b_overflow;
    logic [AW-1:0] b_mem_addr;
    logic [W-1:0]  b_mem_data;
    logic [2:0]    b_level;

    int            checks = 0;
    int            errors = 0;
    bit            mon_en;
    logic [AW-1:0] tile_base, a_exp, b_exp;
    int            a_rows, b_rows, a_dones, b_dones;

    always #5 clk = ~clk;

    ustc_drain #(.M(M), .N(N), .DW_DATA(DW), .DEPTH(16), .AW(AW), .ADDR_STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .base_addr(base_addr), .in_valid(in_valid), .in_data(in_data),
        .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
        .mem_last(a_mem_last), .done(a_done), .overflow(a_overflow), .level(a_level)
    );

    ustc_drain #(.M(M), .N(N), .DW_DATA(DW), .DEPTH(4), .AW(AW), .ADDR_STRIDE(1)) dut_b (
        .clk(clk), .rst(rst), .base_addr(base_addr), .in_valid(in_valid), .in_data(in_data),
        .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
        .mem_last(b_mem_last), .done(b_done), .overflow(b_overflow), .level(b_level)
    );

    // Non-negative elements derived from the row address so data can be checked without a queue.
    function automatic logic [W-1:0] rowData(input logic [AW-1:0] addr);
        logic [W-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) begin
            d[i*DW +: DW] = 8'((addr[7:0] + 8'(i)) & 8'h7F);
        end
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks any row that handshakes at the coming edge, then advances one cycle.
    task automatic tick();
        if (mon_en) begin
            if (a_mem_valid && mem_ready) begin
                checkOutput("a_addr", W'(a_mem_addr), W'(a_exp));
                checkOutput("a_data", a_mem_data, rowData(a_exp));
                checkOutput("a_last", W'(a_mem_last), W'(a_exp == tile_base + 16'd15));
                a_exp = a_exp + 16'd1;
                a_rows++;
            end
            if (b_mem_valid && mem_ready) begin
                checkOutput("b_addr", W'(b_mem_addr), W'(b_exp));
                checkOutput("b_data", b_mem_data, rowData(b_exp));
                checkOutput("b_last", W'(b_mem_last), W'(b_exp == tile_base + 16'd15));
                b_exp = b_exp + 16'd1;
                b_rows++;
            end
        end
        @(posedge clk);
        #1;
        if (a_done) a_dones++;
        if (b_done) b_dones++;
    endtask

    task automatic applyStimulus(input logic valid, input logic [W-1:0] data);
        in_valid = valid;
        in_data  = data;
        tick();
    endtask

    task automatic startTile(input logic [AW-1:0] base);
        tile_base = base;
        base_addr = base;
        a_exp     = base;
        b_exp     = base;
        a_rows    = 0;
        b_rows    = 0;
        a_dones   = 0;
        b_dones   = 0;
    endtask

    task automatic doReset();
        mon_en   = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst      = 1'b0;
    endtask

    task automatic checkReset();
        checkOutput("rst_a_valid", W'(a_mem_valid), '0);
        checkOutput("rst_a_addr",  W'(a_mem_addr),  '0);
        checkOutput("rst_a_data",  a_mem_data,      '0);
        checkOutput("rst_a_last",  W'(a_mem_last),  '0);
        checkOutput("rst_a_done",  W'(a_done),      '0);
        checkOutput("rst_a_ovf",   W'(a_overflow),  '0);
        checkOutput("rst_a_level", W'(a_level),     '0);
        checkOutput("rst_b_valid", W'(b_mem_valid), '0);
        checkOutput("rst_b_addr",  W'(b_mem_addr),  '0);
        checkOutput("rst_b_data",  b_mem_data,      '0);
        checkOutput("rst_b_last",  W'(b_mem_last),  '0);
        checkOutput("rst_b_done",  W'(b_done),      '0);
        checkOutput("rst_b_ovf",   W'(b_overflow),  '0);
        checkOutput("rst_b_level", W'(b_level),     '0);
    endtask

    initial begin
        logic [W-1:0] relu_row;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        base_addr = '0;
        mem_ready = 1'b0;
        mon_en    = 1'b0;
        startTile(16'h0);
        tick();
        tick();
        checkReset();
        rst = 1'b0;

        $display("[TB] single tile");
        startTile(16'h0100);
        mon_en    = 1'b1;
        mem_ready = 1'b1;
        applyStimulus(1'b1, rowData(16'h0100));
        checkOutput("lat_valid_lo", W'(a_mem_valid), '0);
        checkOutput("lat_level",    W'(a_level), W'(1));
        base_addr = 16'hDEAD;
        for (int k = 1; k < M; k++) begin
            applyStimulus(1'b1, rowData(16'h0100 + 16'(k)));
            if (k == 1) begin
                checkOutput("lat_valid_hi", W'(a_mem_valid), W'(1));
                checkOutput("lat_addr",     W'(a_mem_addr), W'(16'h0100));
            end
        end
        applyStimulus(1'b0, '0);
        checkOutput("last_flag", W'(a_mem_last), W'(1));
        checkOutput("done_early", W'(a_done), '0);
        applyStimulus(1'b0, '0);
        checkOutput("done_pulse", W'(a_done), W'(1));
        checkOutput("valid_after", W'(a_mem_valid), '0);
        applyStimulus(1'b0, '0);
        checkOutput("done_clear", W'(a_done), '0);
        checkOutput("t1_a_rows", W'(a_rows), W'(16));
        checkOutput("t1_b_rows", W'(b_rows), W'(16));
        checkOutput("t1_a_dones", W'(a_dones), W'(1));
        checkOutput("t1_b_dones", W'(b_dones), W'(1));

        $display("[TB] over-long burst");
        startTile(16'h0200);
        for (int k = 0; k <= M; k++) begin
            applyStimulus(1'b1, rowData(16'h0200 + 16'(k)));
        end
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0);
        checkOutput("t2_a_rows", W'(a_rows), W'(16));
        checkOutput("t2_b_rows", W'(b_rows), W'(16));
        checkOutput("t2_a_ovf", W'(a_overflow), '0);
        checkOutput("t2_b_ovf", W'(b_overflow), '0);
        checkOutput("t2_a_dones", W'(a_dones), W'(1));

        $display("[TB] backpressure and overflow");
        doReset();
        startTile(16'h0300);
        mon_en    = 1'b1;
        mem_ready = 1'b0;
        for (int k = 0; k < M; k++) begin
            applyStimulus(1'b1, rowData(16'h0300 + 16'(k)));
            if (k >= 1) begin
                checkOutput("stall_a_valid", W'(a_mem_valid), W'(1));
                checkOutput("stall_a_addr",  W'(a_mem_addr), W'(16'h0300));
                checkOutput("stall_a_data",  a_mem_data, rowData(16'h0300));
            end
            if (k == 4) checkOutput("b_ovf_5th", W'(b_overflow), '0);
            if (k == 5) checkOutput("b_ovf_6th", W'(b_overflow), W'(1));
        end
        applyStimulus(1'b0, '0);
        checkOutput("bp_a_level", W'(a_level), W'(15));
        checkOutput("bp_a_ovf",   W'(a_overflow), '0);
        checkOutput("bp_b_level", W'(b_level), W'(4));
        checkOutput("bp_b_ovf",   W'(b_overflow), W'(1));
        mem_ready = 1'b1;
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, '0);
        checkOutput("bp_a_rows",  W'(a_rows), W'(16));
        checkOutput("bp_b_rows",  W'(b_rows), W'(5));
        checkOutput("bp_a_dones", W'(a_dones), W'(1));
        checkOutput("bp_b_dones", W'(b_dones), '0);
        checkOutput("bp_b_ovf_sticky", W'(b_overflow), W'(1));

        $display("[TB] full push/pop");
        doReset();
        startTile(16'h0400);
        mon_en    = 1'b1;
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, rowData(16'h0400 + 16'(k)));
        checkOutput("fp_b_level_fill", W'(b_level), W'(4));
        mem_ready = 1'b1;
        for (int k = 5; k < M; k++) begin
            applyStimulus(1'b1, rowData(16'h0400 + 16'(k)));
            checkOutput("fp_b_level", W'(b_level), W'(4));
        end
        checkOutput("fp_b_ovf", W'(b_overflow), '0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, '0);
        checkOutput("fp_b_rows",  W'(b_rows), W'(16));
        checkOutput("fp_b_dones", W'(b_dones), W'(1));
        checkOutput("fp_b_ovf_end", W'(b_overflow), '0);

        $display("[TB] element pass/clamp");
        doReset();
        startTile(16'h0500);
        mem_ready = 1'b1;
        relu_row  = {(N - 2){8'h05}};
        relu_row  = {relu_row[W-17:0], 8'h7F, 8'h80};
        applyStimulus(1'b1, relu_row);
        applyStimulus(1'b0, '0);
        checkOutput("relu_valid", W'(a_mem_valid), W'(1));
        checkOutput("relu_neg",   W'(a_mem_data[7:0]), W'(NEG_EXP));
        checkOutput("relu_pos",   W'(a_mem_data[15:8]), W'(8'h7F));
        checkOutput("relu_other", W'(a_mem_data[23:16]), W'(8'h05));
        checkOutput("relu_addr",  W'(a_mem_addr), W'(16'h0500));
        applyStimulus(1'b0, '0);

        $display("[TB] reset mid-drain");
        doReset();
        startTile(16'h0600);
        mon_en    = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, rowData(16'h0600 + 16'(k)));
        checkOutput("md_rows_before", W'(a_rows), W'(3));
        mon_en   = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = rowData(16'h0605);
        tick();
        checkReset();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        checkOutput("md_a_done",  W'(a_done), '0);
        checkOutput("md_b_done",  W'(b_done), '0);
        checkOutput("md_a_level", W'(a_level), '0);
        checkOutput("md_a_valid", W'(a_mem_valid), '0);
        checkOutput("md_dones",   W'(a_dones + b_dones), '0);
        startTile(16'h0700);
        mon_en = 1'b1;
        for (int k = 0; k < M; k++) applyStimulus(1'b1, rowData(16'h0700 + 16'(k)));
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0);
        checkOutput("fresh_a_rows",  W'(a_rows), W'(16));
        checkOutput("fresh_b_rows",  W'(b_rows), W'(16));
        checkOutput("fresh_a_dones", W'(a_dones), W'(1));
        checkOutput("fresh_b_dones", W'(b_dones), W'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
